meas_uart_tx: RTL and testbench
===============================

# meas_uart_tx

Serialises each completed frequency measurement onto a UART line as readable ASCII text. It sits directly downstream of the oscillator tester and consumes its 8-bit `measure` bus and `data_valid` flag. Each new measurement is emitted as three decimal digits plus CR LF, e.g. 125 kHz → "125\r\n". It lets a host terminal log ring-oscillator frequencies without a logic analyser.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 87: clocks per UART bit (10 MHz / 115200); legal range 2..4095.

Ports:
- `clk` in 1: system clock; the same clock as the tester.
- `rst_n` in 1: asynchronous, active-low reset.
- `measure` in 8: measurement in kHz, 0..255; sampled only on a `data_valid` rising edge.
- `data_valid` in 1: level from the tester; a rising edge marks a new measurement.
- `tx` out 1: UART line, 8N1, LSB first, idles high.
- `busy` out 1: high while a conversion or frame is in progress.
- `overrun` out 1: sticky; set when a pending measurement is overwritten before it is sent.

## Operation
- **Edge detect:** `dv_q <= data_valid`; `dv_rise = data_valid & ~dv_q`.
- **Pending buffer:** one 8-bit register plus a `pend` flag.
  - `dv_rise` loads `measure` into the buffer and sets `pend`.
  - If `pend` is already set on that cycle, overwrite the buffer and set `overrun`.
- **FSM states:** IDLE, CONVERT, LOAD, SEND, NEXT.
  - IDLE: if `pend`, copy buffer → `value`, clear `pend`, go to CONVERT.
  - CONVERT: 8-cycle double-dabble (shift-add-3), producing 3 BCD digits (hundreds ≤ 2), then go to LOAD.
  - LOAD: select character `idx` (0..4) = {0x30+H, 0x30+T, 0x30+U, 0x0D, 0x0A}, start the serializer, go to SEND.
  - SEND: wait for the serializer's `done`, then go to NEXT.
  - NEXT: if `idx` == 4, set `idx` = 0 and go to IDLE; else increment `idx` and go to LOAD.
- **Leading zeros:** always emitted (7 → "007\r\n"). The frame is fixed at 5 characters.
- **Serializer:** start bit 0, data bits 0..7 LSB first, stop bit 1. Each bit is held exactly `CLKS_PER_BIT` clocks. The baud counter restarts at every start.
- **Simultaneous pend-set and pend-clear:** when `dv_rise` and the IDLE→CONVERT transition fall on the same cycle, the new value goes into the buffer and `pend` stays set. No overrun is flagged.
- **Arrivals during a frame:** a `dv_rise` during CONVERT, LOAD, SEND or NEXT only fills the buffer. It never alters the frame in flight.
- `overrun` clears only on reset.

## Timing
- **Reset values:** `tx` = 1, `busy` = 0, `overrun` = 0, `pend` = 0, state IDLE, `idx` = 0. `rst_n` low mid-frame forces `tx` high asynchronously and abandons the frame.
- **Cycle numbering** (C = cycle in which `data_valid` is first sampled high):
  - C: `dv_rise` registered into buffer.
  - C+1: IDLE → CONVERT; `busy` rises.
  - C+2..C+9: conversion steps.
  - C+10: LOAD.
  - C+11: `tx` falls (first start bit).
- **Character time:** 10·`CLKS_PER_BIT` clocks of line activity, plus 2 clocks of LOAD/NEXT overhead before the next start bit.
- **Frame length:** 5·(10·`CLKS_PER_BIT` + 2) + 9 clocks from `busy` rise to `busy` fall. `busy` falls in the cycle the FSM re-enters IDLE.
- **Back-to-back frames:** with `pend` set, the next frame's `busy` re-asserts one cycle after entering IDLE.

## Structure
- **Shared package `meas_uart_pkg`:** FSM state enum; ASCII constants `ASCII_ZERO` (0x30), `ASCII_CR` (0x0D), `ASCII_LF` (0x0A); `CHARS_PER_FRAME` = 5.
- **Sub-module `uart_tx_byte`:**
  - Ports: `clk`, `rst_n`, `start`, `data[7:0]`, `tx`, `done`.
  - `done` is a one-cycle pulse in the last clock of the stop bit.
  - Reusable by later debug blocks.
- **Top level:** contains the edge detect, pending buffer, double-dabble, and character mux.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4.
- **Reset idle:** hold `rst_n` low, then release → `tx` = 1, `busy` = 0, `overrun` = 0; no line activity for 200 clocks.
- **Single value 125:** `measure` = 125, pulse `data_valid` → `tx` falls exactly 11 clocks after the edge. Decoded bytes are 0x31 0x32 0x35 0x0D 0x0A. `busy` is high for 5·42+9 = 219 clocks.
- **Boundary values 0 and 255:**
  - 0 → "000\r\n".
  - 255 → "255\r\n".
  - Hold `data_valid` high for 50 clocks → exactly one frame.
- **Queued and overrun:**
  - Send 10, then 20 during the frame → "010\r\n" then "020\r\n" back-to-back; `overrun` = 0.
  - Send 10, then 20, then 30, the latter two both during the first frame → frames "010\r\n" and "030\r\n"; `overrun` = 1.
- **Reset mid-frame:** assert `rst_n` low during the 2nd character's data bits → `tx` = 1 immediately, `busy` = 0. After release, a new value 42 yields a clean "042\r\n".

Source files
------------

// File: rtl/meas_uart_pkg.sv
// Shared definitions for the measurement-to-UART path.
// Provides the frame FSM state type, the ASCII constants used to build a
// "DDD\r\n" frame, and the shift-add-3 digit correction used by the binary to
// BCD converter.
package meas_uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StLoad,
    StSend,
    StNext
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  localparam int unsigned CHARS_PER_FRAME = 5;
  // One double-dabble step per bit of the 8-bit measurement.
  localparam int unsigned DABBLE_STEPS    = 8;

  // Double-dabble correction: a digit of 5 or more would overflow past 9
  // after the following left shift, so bias it by 3 first.
  function automatic logic [3:0] add3(input logic [3:0] digit);
    return (digit >= 4'd5) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : one-cycle request; latches data and (re)starts a frame
//   data[7:0]  : byte to send, LSB first
//   tx         : serial line, idles high, registered
//   done       : one-cycle pulse in the last clock of the stop bit
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned CntW = 12;

  logic [CntW-1:0] baud_q;
  logic [3:0]      bit_q;    // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]      shift_q;
  logic            active_q;
  logic            tx_q;
  logic            bit_end;

  assign bit_end = (baud_q == CntW'(CLKS_PER_BIT - 1));
  assign done    = active_q & bit_end & (bit_q == 4'd9);
  assign tx      = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      active_q <= 1'b0;
      tx_q     <= 1'b1;
    end else if (start) begin
      tx_q     <= 1'b0;
      shift_q  <= data;
      baud_q   <= '0;
      bit_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (bit_end) begin
        baud_q <= '0;
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
        end else begin
          bit_q   <= bit_q + 4'd1;
          tx_q    <= shift_q[0];
          // Ones shifted in from the top become the stop bit after 8 shifts.
          shift_q <= {1'b1, shift_q[7:1]};
        end
      end else begin
        baud_q <= baud_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/meas_uart_tx.sv
// Prints each new frequency measurement on a UART as "DDD\r\n".
// Ports:
//   clk, rst_n   : clock and asynchronous active-low reset
//   measure[7:0] : measurement in kHz, captured on a data_valid rising edge
//   data_valid   : level from the tester; rising edge = new measurement
//   tx           : UART line, 8N1, idles high
//   busy         : high while a conversion or frame is in progress
//   overrun      : sticky; a pending measurement was overwritten unsent
module meas_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] measure,
  input  logic       data_valid,
  output logic       tx,
  output logic       busy,
  output logic       overrun
);

  import meas_uart_pkg::*;

  state_e      state_q;
  logic        dv_q;
  logic [7:0]  pend_val_q;
  logic        pend_q;
  logic        overrun_q;
  logic        busy_q;
  logic        start_q;
  logic [2:0]  idx_q;
  logic [3:0]  cnt_q;
  logic [7:0]  value_q;
  logic [11:0] bcd_q;     // {hundreds, tens, units}
  logic [7:0]  tx_char;
  logic        tx_done;
  logic        dv_rise;
  logic        take;

  assign dv_rise = data_valid & ~dv_q;
  // The FSM consumes the pending value in this cycle.
  assign take    = (state_q == StIdle) & pend_q;

  always_comb begin
    tx_char = ASCII_LF;
    unique case (idx_q)
      3'd0:    tx_char = ASCII_ZERO + {4'd0, bcd_q[11:8]};
      3'd1:    tx_char = ASCII_ZERO + {4'd0, bcd_q[7:4]};
      3'd2:    tx_char = ASCII_ZERO + {4'd0, bcd_q[3:0]};
      3'd3:    tx_char = ASCII_CR;
      default: tx_char = ASCII_LF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dv_q       <= 1'b0;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      value_q    <= '0;
      bcd_q      <= '0;
    end else begin
      dv_q    <= data_valid;
      start_q <= 1'b0;

      // A new arrival always wins the buffer; it is only an overrun if the
      // previous value is not being consumed in the same cycle.
      if (dv_rise) begin
        pend_val_q <= measure;
        pend_q     <= 1'b1;
        if (pend_q && !take) begin
          overrun_q <= 1'b1;
        end
      end else if (take) begin
        pend_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (pend_q) begin
            value_q <= pend_val_q;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StConvert;
          end
        end
        StConvert: begin
          if (cnt_q == 4'(DABBLE_STEPS)) begin
            start_q <= 1'b1;
            state_q <= StLoad;
          end else begin
            // Hundreds never exceeds 2 for an 8-bit input, so it needs no
            // correction; tens and units are adjusted before the shift.
            bcd_q   <= {bcd_q[10:8], add3(bcd_q[7:4]), add3(bcd_q[3:0]), value_q[7]};
            value_q <= {value_q[6:0], 1'b0};
            cnt_q   <= cnt_q + 4'd1;
          end
        end
        StLoad: begin
          state_q <= StSend;
        end
        StSend: begin
          if (tx_done) begin
            state_q <= StNext;
          end
        end
        StNext: begin
          if (idx_q == 3'(CHARS_PER_FRAME - 1)) begin
            idx_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            idx_q   <= idx_q + 3'd1;
            start_q <= 1'b1;
            state_q <= StLoad;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start_q),
    .data (tx_char),
    .tx   (tx),
    .done (tx_done)
  );

  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_meas_uart_tx.sv
module tb_meas_uart_tx;

  localparam int unsigned Cpb       = 4;
  localparam int unsigned CharClks  = 10 * Cpb + 2;
  localparam int unsigned FrameClks = 5 * CharClks + 9;

  logic       clk;
  logic       rst_n;
  logic [7:0] measure;
  logic       data_valid;
  logic       tx;
  logic       busy;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int ferr   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_byte;
  logic       mon_ok;
  logic       mon_stop;

  meas_uart_tx #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .measure   (measure),
    .data_valid(data_valid),
    .tx        (tx),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line decoder: samples on falling clock edges near the middle of each bit.
  // Bytes cut short by a reset are discarded.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        mon_ok = 1'b1;
        @(negedge clk);
        if (tx !== 1'b0) mon_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (Cpb) @(negedge clk);
          mon_byte[i] = tx;
          if (rst_n !== 1'b1) mon_ok = 1'b0;
        end
        repeat (Cpb) @(negedge clk);
        mon_stop = tx;
        if (rst_n !== 1'b1) mon_ok = 1'b0;
        if (mon_ok) begin
          if (mon_stop !== 1'b1) ferr++;
          rx_q.push_back(mon_byte);
        end
      end
    end
  end

  // Reference: a value prints as three decimal digits then CR LF.
  function automatic void push_frame(input int v);
    exp_q.push_back(8'(48 + v / 100));
    exp_q.push_back(8'(48 + (v / 10) % 10));
    exp_q.push_back(8'(48 + v % 10));
    exp_q.push_back(8'h0d);
    exp_q.push_back(8'h0a);
  endfunction

  task automatic pulse_dv(input logic [7:0] v, input int hold);
    @(posedge clk);
    #1;
    measure    = v;
    data_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic wait_quiet(output bit timed_out);
    int quiet = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b0) quiet++;
      else quiet = 0;
      if (quiet >= 20) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int act = 0;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    measure    = 8'd0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) act++;
    end
    checks++;
    if (act != 0) begin errors++; $display("FAIL reset_idle: %0d active cycles, want 0", act); end
    checks++;
    if (rx_q.size() != 0) begin errors++; $display("FAIL reset_rx: got %0d bytes want 0", rx_q.size()); end
  endtask

  task automatic test_single();
    int tx_fall = 0;
    int busy_rise = 0;
    int busy_len = 0;
    bit to;
    rx_q.delete();
    exp_q.delete();
    push_frame(125);
    @(posedge clk);
    #1;
    measure    = 8'd125;
    data_valid = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) data_valid = 1'b0;
      if (tx_fall == 0 && tx === 1'b0) tx_fall = c;
      if (busy === 1'b1) begin
        busy_len++;
        if (busy_rise == 0) busy_rise = c;
      end else if (busy_rise != 0) begin
        break;
      end
    end
    checks++;
    if (tx_fall - 1 != 11) begin
      errors++; $display("FAIL single_tx_latency: got %0d want 11", tx_fall - 1);
    end
    checks++;
    if (busy_rise - 1 != 1) begin
      errors++; $display("FAIL single_busy_latency: got %0d want 1", busy_rise - 1);
    end
    checks++;
    if (busy_len != FrameClks) begin
      errors++; $display("FAIL single_busy_len: got %0d want %0d", busy_len, FrameClks);
    end
    wait_quiet(to);
    checks++;
    if (to) begin errors++; $display("FAIL single_timeout: busy never settled low"); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_count: got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL single_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_boundary();
    int vals[3];
    int holds[3];
    bit to;
    vals[0] = 0;
    vals[1] = 255;
    vals[2] = int'($urandom_range(0, 255));
    holds[0] = 2;
    holds[1] = 2;
    holds[2] = 50;
    for (int k = 0; k < 3; k++) begin
      rx_q.delete();
      exp_q.delete();
      push_frame(vals[k]);
      pulse_dv(8'(vals[k]), holds[k]);
      wait_quiet(to);
      checks++;
      if (to) begin errors++; $display("FAIL boundary_timeout: value %0d", vals[k]); end
      checks++;
      if (rx_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL boundary_count: value %0d got %0d bytes want %0d",
                 vals[k], rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        checks++;
        if (rx_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL boundary_byte%0d: value %0d got %h want %h", i, vals[k], rx_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit to;
    rx_q.delete();
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      int v;
      v = int'($urandom_range(0, 255));
      push_frame(v);
      pulse_dv(8'(v), int'($urandom_range(1, 6)));
      wait_quiet(to);
      checks++;
      if (to) begin errors++; $display("FAIL random_timeout: value %0d", v); end
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL random_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int gap = 0;
    int falls = 0;
    logic prev;
    bit to;
    rx_q.delete();
    exp_q.delete();
    push_frame(10);
    push_frame(20);
    pulse_dv(8'd10, 2);
    repeat (30) @(posedge clk);
    pulse_dv(8'd20, 2);
    prev = busy;
    for (int c = 0; c < 1200; c++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b0 && prev === 1'b1) falls++;
      if (busy === 1'b0 && falls == 1) gap++;
      prev = busy;
    end
    checks++;
    if (falls != 2) begin errors++; $display("FAIL b2b_falls: got %0d busy falls want 2", falls); end
    checks++;
    if (gap != 1) begin errors++; $display("FAIL b2b_gap: busy low %0d cycles want 1", gap); end
    wait_quiet(to);
    checks++;
    if (to) begin errors++; $display("FAIL b2b_timeout: busy never settled low"); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_overrun();
    int b;
    int c;
    bit to;
    b = int'($urandom_range(0, 255));
    c = int'($urandom_range(0, 255));
    rx_q.delete();
    exp_q.delete();
    // Only the last arrival during a frame survives.
    push_frame(10);
    push_frame(c);
    pulse_dv(8'd10, 2);
    repeat (30) @(posedge clk);
    pulse_dv(8'(b), 2);
    repeat (30) @(posedge clk);
    pulse_dv(8'(c), 2);
    wait_quiet(to);
    checks++;
    if (to) begin errors++; $display("FAIL ovr_timeout: busy never settled low"); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ovr_count: got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovr_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int v;
    bit to;
    logic [7:0] first;
    v = int'($urandom_range(0, 255));
    first = 8'(48 + v / 100);
    rx_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    measure    = 8'(v);
    data_valid = 1'b1;
    for (int c = 1; c <= 65; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) data_valid = 1'b0;
    end
    // Middle of the second character's data bits.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b want 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b want 0", overrun); end
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    checks++;
    if (rx_q.size() != 1) begin
      errors++; $display("FAIL rstmid_partial: got %0d bytes want 1", rx_q.size());
    end else begin
      checks++;
      if (rx_q[0] !== first) begin
        errors++; $display("FAIL rstmid_first: got %h want %h", rx_q[0], first);
      end
    end
    rx_q.delete();
    push_frame(42);
    pulse_dv(8'd42, 2);
    wait_quiet(to);
    checks++;
    if (to) begin errors++; $display("FAIL rstmid_timeout: busy never settled low"); end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rstmid_count: got %0d bytes want %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rstmid_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_random();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    checks++;
    if (ferr != 0) begin errors++; $display("FAIL stop_bits: got %0d framing errors want 0", ferr); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
